// File: rtl/instruction_decode_pkg.sv
// Shared opcode/funct constants and control bundle for fetch, decode, execute.
// Also holds small helpers for classifying opcodes.
package instruction_decode_pkg;

   localparam int NB_OPCODE = 6;
   localparam int NB_FUNCT  = 6;
   localparam int NB_SHAMT  = 5;

   localparam logic [NB_OPCODE-1:0] OP_RTYPE = 6'b000000;
   localparam logic [NB_OPCODE-1:0] OP_J     = 6'b000010;
   localparam logic [NB_OPCODE-1:0] OP_JAL   = 6'b000011;
   localparam logic [NB_OPCODE-1:0] OP_BEQ   = 6'b000100;
   localparam logic [NB_OPCODE-1:0] OP_BNE   = 6'b000101;
   localparam logic [NB_OPCODE-1:0] OP_ANDI  = 6'b001100;
   localparam logic [NB_OPCODE-1:0] OP_ORI   = 6'b001101;
   localparam logic [NB_OPCODE-1:0] OP_XORI  = 6'b001110;

   localparam logic [NB_FUNCT-1:0] FN_JR   = 6'b001000;
   localparam logic [NB_FUNCT-1:0] FN_JALR = 6'b001001;

   localparam logic [2:0] CLS_LOAD  = 3'b100;
   localparam logic [2:0] CLS_STORE = 3'b101;

   typedef struct packed {
      logic reg_we;
      logic mem_read;
      logic mem_write;
      logic alu_src;
   } ctrl_t;

   function automatic logic is_zext(input logic [NB_OPCODE-1:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

   function automatic logic is_store(input logic [NB_OPCODE-1:0] op);
      return op[5:3] == CLS_STORE;
   endfunction

   function automatic logic is_load(input logic [NB_OPCODE-1:0] op);
      return op[5:3] == CLS_LOAD;
   endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// Register file: two read ports, one write port, write-through reads.
// Register 0 is hardwired to zero.
module register_file
   import instruction_decode_pkg::*;
#(
   parameter int NB_REG      = 32,
   parameter int N_REGS      = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_we,
   input  logic [NB_REG_ADDR-1:0] i_wr_addr,
   input  logic [NB_REG-1:0]      i_wr_data,
   input  logic [NB_REG_ADDR-1:0] i_rd_addr_a,
   input  logic [NB_REG_ADDR-1:0] i_rd_addr_b,
   output logic [NB_REG-1:0]      o_rd_data_a,
   output logic [NB_REG-1:0]      o_rd_data_b
);

   logic [NB_REG-1:0] regs [N_REGS];
   logic              wr_ok;

   assign wr_ok = i_we && (i_wr_addr != '0);

   // Storage: cleared on reset, written when enabled and not r0.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         regs[i_wr_addr] <= i_wr_data;
      end
   end

   // Reads bypass a same-cycle write to the same address.
   always_comb begin
      o_rd_data_a = regs[i_rd_addr_a];
      o_rd_data_b = regs[i_rd_addr_b];
      if (i_rd_addr_a == '0) begin
         o_rd_data_a = '0;
      end else if (wr_ok && (i_wr_addr == i_rd_addr_a)) begin
         o_rd_data_a = i_wr_data;
      end
      if (i_rd_addr_b == '0) begin
         o_rd_data_b = '0;
      end else if (wr_ok && (i_wr_addr == i_rd_addr_b)) begin
         o_rd_data_b = i_wr_data;
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: ID register, register file, hazard/transfer detection,
// and the registered bundle handed to EX.
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int NB_REG      = 32,
   parameter int NB_INSTR    = 32,
   parameter int NB_INM_I    = 16,
   parameter int NB_INM_J    = 26,
   parameter int N_REGS      = 32,
   parameter int NB_REG_ADDR = 5
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_valid,
   input  logic [NB_INSTR-1:0]    i_ir,
   input  logic [NB_REG-1:0]      i_pc,
   input  logic                   i_wb_we,
   input  logic [NB_REG_ADDR-1:0] i_wb_addr,
   input  logic [NB_REG-1:0]      i_wb_data,
   input  logic                   i_ex_mem_read,
   input  logic [NB_REG_ADDR-1:0] i_ex_rt_addr,
   output logic                   o_jump_inm,
   output logic                   o_jump_rs,
   output logic                   o_branch,
   output logic                   o_hazard,
   output logic                   o_nop_reg,
   output logic [NB_INM_I-1:0]    o_inm_i,
   output logic [NB_INM_J-1:0]    o_inm_j,
   output logic [NB_REG-1:0]      o_rs,
   output logic [NB_REG-1:0]      o_rs_data,
   output logic [NB_REG-1:0]      o_rt_data,
   output logic [NB_REG-1:0]      o_inm_ext,
   output logic [NB_REG-1:0]      o_pc,
   output logic [NB_SHAMT-1:0]    o_shamt,
   output logic [NB_REG_ADDR-1:0] o_rt_addr,
   output logic [NB_REG_ADDR-1:0] o_dst_addr,
   output logic [NB_OPCODE-1:0]   o_opcode,
   output logic [NB_FUNCT-1:0]    o_funct,
   output logic                   o_reg_we,
   output logic                   o_mem_read,
   output logic                   o_mem_write,
   output logic                   o_alu_src
);

   logic [NB_INSTR-1:0]    id_instr;
   logic [NB_REG-1:0]      id_pc;

   logic [NB_OPCODE-1:0]   opcode;
   logic [NB_FUNCT-1:0]    funct;
   logic [NB_SHAMT-1:0]    shamt;
   logic [NB_REG_ADDR-1:0] rs_addr;
   logic [NB_REG_ADDR-1:0] rt_addr;
   logic [NB_REG_ADDR-1:0] rd_addr;
   logic [NB_REG-1:0]      rs_data;
   logic [NB_REG-1:0]      rt_data;

   logic                   is_r;
   logic                   is_beq;
   logic                   is_bne;
   logic                   is_j;
   logic                   is_jal;
   logic                   is_jr;
   logic                   hazard;
   ctrl_t                  ctrl_d;
   ctrl_t                  ctrl_q;
   logic [NB_REG_ADDR-1:0] dst_d;
   logic [NB_REG-1:0]      inm_ext_d;

   assign opcode  = id_instr[31:26];
   assign rs_addr = id_instr[25:21];
   assign rt_addr = id_instr[20:16];
   assign rd_addr = id_instr[15:11];
   assign shamt   = id_instr[10:6];
   assign funct   = id_instr[5:0];

   register_file #(
      .NB_REG      (NB_REG),
      .N_REGS      (N_REGS),
      .NB_REG_ADDR (NB_REG_ADDR)
   ) u_register_file (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_we        (i_valid && i_wb_we),
      .i_wr_addr   (i_wb_addr),
      .i_wr_data   (i_wb_data),
      .i_rd_addr_a (rs_addr),
      .i_rd_addr_b (rt_addr),
      .o_rd_data_a (rs_data),
      .o_rd_data_b (rt_data)
   );

   // ID register: advances unless frozen or stalled by a load-use hazard.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         id_instr <= '0;
         id_pc    <= '0;
      end else if (i_valid && !hazard) begin
         id_instr <= i_ir;
         id_pc    <= i_pc;
      end
   end

   // Decode: hazard, pc transfers, and the EX control bundle.
   always_comb begin
      is_r   = (opcode == OP_RTYPE);
      is_beq = (opcode == OP_BEQ);
      is_bne = (opcode == OP_BNE);
      is_j   = (opcode == OP_J);
      is_jal = (opcode == OP_JAL);
      is_jr  = is_r && (funct == FN_JR);

      hazard = i_ex_mem_read
            && (i_ex_rt_addr != '0)
            && ((i_ex_rt_addr == rs_addr)
               || ((is_r || is_beq || is_bne || is_store(opcode))
                  && (i_ex_rt_addr == rt_addr)));

      o_jump_inm = !hazard && (is_j || is_jal);
      o_jump_rs  = !hazard && is_r
                && ((funct == FN_JR) || (funct == FN_JALR));
      o_branch   = !hazard
                && ((is_beq && (rs_data == rt_data))
                   || (is_bne && (rs_data != rt_data)));

      ctrl_d.reg_we    = !(is_store(opcode) || is_beq || is_bne
                        || is_j || is_jr || (id_instr == '0));
      ctrl_d.mem_read  = is_load(opcode);
      ctrl_d.mem_write = is_store(opcode);
      ctrl_d.alu_src   = !(is_r || is_beq || is_bne || is_j || is_jal);

      dst_d = rt_addr;
      if (is_r) begin
         dst_d = rd_addr;
      end else if (is_jal) begin
         dst_d = {NB_REG_ADDR{1'b1}};
      end

      if (is_zext(opcode)) begin
         inm_ext_d = {{(NB_REG-NB_INM_I){1'b0}}, id_instr[NB_INM_I-1:0]};
      end else begin
         inm_ext_d = {{(NB_REG-NB_INM_I){id_instr[NB_INM_I-1]}},
                      id_instr[NB_INM_I-1:0]};
      end
   end

   assign o_hazard = hazard;
   assign o_inm_i  = id_instr[NB_INM_I-1:0];
   assign o_inm_j  = id_instr[NB_INM_J-1:0];
   assign o_rs     = rs_data;

   // Marks the slot right after a taken transfer so fetch can squash it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_nop_reg <= 1'b0;
      end else if (i_valid) begin
         o_nop_reg <= o_jump_inm || o_jump_rs || o_branch;
      end
   end

   // EX register: loads decoded fields, or a zero bubble on a stall.
   always_ff @(posedge i_clock) begin
      if (i_reset || (i_valid && hazard)) begin
         o_rs_data  <= '0;
         o_rt_data  <= '0;
         o_inm_ext  <= '0;
         o_pc       <= '0;
         o_shamt    <= '0;
         o_rt_addr  <= '0;
         o_dst_addr <= '0;
         o_opcode   <= '0;
         o_funct    <= '0;
         ctrl_q     <= '0;
      end else if (i_valid) begin
         o_rs_data  <= rs_data;
         o_rt_data  <= rt_data;
         o_inm_ext  <= inm_ext_d;
         o_pc       <= id_pc;
         o_shamt    <= shamt;
         o_rt_addr  <= rt_addr;
         o_dst_addr <= dst_d;
         o_opcode   <= opcode;
         o_funct    <= funct;
         ctrl_q     <= ctrl_d;
      end
   end

   assign o_reg_we    = ctrl_q.reg_we;
   assign o_mem_read  = ctrl_q.mem_read;
   assign o_mem_write = ctrl_q.mem_write;
   assign o_alu_src   = ctrl_q.alu_src;

endmodule
